rf_wb_arbiter: RTL and testbench



---
 rtl/rf_pkg.sv | 42 ++++
 rtl/rf_wb_fifo.sv | 75 +++++++
 rtl/rf_wb_arbiter.sv | 241 ++++++++++++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg -- definitions shared by the register-file writeback arbiter.
//
// Contents:
//   REG_ADDR_W / NUM_REGS / ZERO_REG : register file geometry
//   RF_DATA_W                        : default datapath width
//   reg_addr_t                       : register index type
//   wb_req_t                         : {valid, rd, data} write request record
//   wr_src_e                         : which requester owns the write port
//   reg_onehot()                     : register index -> one-hot busy mask
// ---------------------------------------------------------------------------
package rf_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int RF_DATA_W  = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = '0;

    // Canonical write request at the default datapath width. The top keeps
    // its own fields so that DATA_WIDTH can be overridden per instance.
    typedef struct packed {
        logic                 valid;
        reg_addr_t            rd;
        logic [RF_DATA_W-1:0] data;
    } wb_req_t;

    // Owner of the register file write port in the current cycle.
    typedef enum logic [1:0] {
        SRC_NONE   = 2'd0,
        SRC_WB     = 2'd1,
        SRC_FIFO   = 2'd2,
        SRC_BYPASS = 2'd3
    } wr_src_e;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_addr_t r);
        return NUM_REGS'(1) << r;
    endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// ---------------------------------------------------------------------------
// rf_wb_fifo -- synchronous FIFO holding long-latency results that lost
// arbitration for the register file write port.
//
// Parameters: WIDTH (entry width), DEPTH (entries, power of two, >= 2)
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   push_i, wdata_i   write request and data (ignored while full)
//   pop_i             remove head (ignored while empty)
//   head_o            current head entry (valid while !empty_o)
//   full_o, empty_o   occupancy flags
//
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate counter.
// ---------------------------------------------------------------------------
module rf_wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign head_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter -- owns the single register file write port and shares it
// between the in-order writeback stage and the long-latency unit.
//
// Parameters:
//   DATA_WIDTH  register data width
//   FIFO_DEPTH  buffered long-latency results (power of two, >= 2)
//   STARVE_MAX  consecutive losses of a non-empty buffer before wb_hold
//               (must be >= 1)
//
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   wb_valid_i/wb_rd_i/wb_data_i      pipeline writeback request
//   wb_accept_o                       pipeline write granted this cycle
//   wb_hold_o                         registered; pipeline freezes writeback
//   lu_valid_i/lu_rd_i/lu_data_i      long-latency result
//   lu_ready_o                        result accepted on valid && ready
//   iss_valid_i/iss_long_i/iss_rd_i   issue-time scoreboard set
//   chk_rs1_i/chk_rs2_i/chk_rd_i      decode-stage registers to check
//   hazard_o                          decode must stall (RAW on rs1/rs2,
//                                     WAW on rd)
//   rf_wr_en_o/addr_o/data_o          register file write port; the file
//                                     commits on the following negedge
//
// Handshake: a long-latency result transfers in any cycle where lu_valid_i
// and lu_ready_o are both high; it is either written straight through
// (buffer empty, pipeline idle) or pushed to the buffer tail. lu_ready_o
// is low whenever the buffer is full, even if it pops that cycle.
//
// Build option: define RF_WB_EARLY_CLEAR_EN to let hazard_o ignore the busy
// bit of the register being written by a long-latency result this cycle.
// That is safe because the register file writes on the negedge, before
// decode samples its read data, and saves one stall cycle per result.
// ---------------------------------------------------------------------------
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  wb_valid_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    output logic                  wb_accept_o,
    output logic                  wb_hold_o,

    input  logic                  lu_valid_i,
    input  logic [REG_ADDR_W-1:0] lu_rd_i,
    input  logic [DATA_WIDTH-1:0] lu_data_i,
    output logic                  lu_ready_o,

    input  logic                  iss_valid_i,
    input  logic                  iss_long_i,
    input  logic [REG_ADDR_W-1:0] iss_rd_i,

    input  logic [REG_ADDR_W-1:0] chk_rs1_i,
    input  logic [REG_ADDR_W-1:0] chk_rs2_i,
    input  logic [REG_ADDR_W-1:0] chk_rd_i,
    output logic                  hazard_o,

    output logic                  rf_wr_en_o,
    output logic [REG_ADDR_W-1:0] rf_wr_addr_o,
    output logic [DATA_WIDTH-1:0] rf_wr_data_o
);

    localparam int               ENTRY_W    = REG_ADDR_W + DATA_WIDTH;
    localparam int               SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]    STARVE_LIM = SW'(STARVE_MAX);

    // ------------------------------------------------------------------
    // Result buffer
    // ------------------------------------------------------------------
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ENTRY_W-1:0]    fifo_head;
    logic [REG_ADDR_W-1:0] head_rd;
    logic [DATA_WIDTH-1:0] head_data;

    rf_wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i ({lu_rd_i, lu_data_i}),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign {head_rd, head_data} = fifo_head;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [SW-1:0]       starve_q, starve_d;
    logic                wb_hold_q, wb_hold_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q    <= '0;
            starve_q  <= '0;
            wb_hold_q <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            starve_q  <= starve_d;
            wb_hold_q <= wb_hold_d;
        end
    end

    // ------------------------------------------------------------------
    // Arbitration: a held pipeline yields to the buffer first; otherwise the
    // pipeline wins, then the buffer, then a direct long-latency bypass.
    // ------------------------------------------------------------------
    wr_src_e               src;
    logic [REG_ADDR_W-1:0] grant_rd;
    logic [DATA_WIDTH-1:0] grant_data;
    logic                  lu_write;

    always_comb begin
        src = SRC_NONE;
        if (!reset) begin
            if (wb_hold_q && !fifo_empty) begin
                src = SRC_FIFO;
            end else if (wb_valid_i) begin
                src = SRC_WB;
            end else if (!fifo_empty) begin
                src = SRC_FIFO;
            end else if (lu_valid_i) begin
                src = SRC_BYPASS;
            end
        end
    end

    always_comb begin
        grant_rd   = ZERO_REG;
        grant_data = '0;
        case (src)
            SRC_WB: begin
                grant_rd   = wb_rd_i;
                grant_data = wb_data_i;
            end
            SRC_FIFO: begin
                grant_rd   = head_rd;
                grant_data = head_data;
            end
            SRC_BYPASS: begin
                grant_rd   = lu_rd_i;
                grant_data = lu_data_i;
            end
            default: begin
                grant_rd   = ZERO_REG;
                grant_data = '0;
            end
        endcase
    end

    assign lu_write = (src == SRC_FIFO) || (src == SRC_BYPASS);

    assign wb_accept_o  = (src == SRC_WB);
    assign lu_ready_o   = !reset && !fifo_full;
    assign fifo_pop     = (src == SRC_FIFO);
    // A bypassed result is consumed directly; every other accepted one queues.
    assign fifo_push    = lu_valid_i && lu_ready_o && (src != SRC_BYPASS);

    // x0 requests still win arbitration and retire, but never reach the file.
    assign rf_wr_en_o   = (src != SRC_NONE) && (grant_rd != ZERO_REG);
    assign rf_wr_addr_o = grant_rd;
    assign rf_wr_data_o = grant_data;

    // ------------------------------------------------------------------
    // Busy scoreboard: set on long issue, cleared when the long result is
    // written. Set is applied after clear so a same-cycle reissue wins.
    // ------------------------------------------------------------------
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;
    logic [NUM_REGS-1:0] hz_busy;

    assign set_mask = (iss_valid_i && iss_long_i && (iss_rd_i != ZERO_REG))
                      ? reg_onehot(iss_rd_i) : '0;
    assign clr_mask = lu_write ? reg_onehot(grant_rd) : '0;

    assign busy_d = ((busy_q & ~clr_mask) | set_mask) & ~reg_onehot(ZERO_REG);

`ifdef RF_WB_EARLY_CLEAR_EN
    assign hz_busy = busy_q & ~clr_mask;
`else
    assign hz_busy = busy_q;
`endif

    assign hazard_o = !reset &&
                      (hz_busy[chk_rs1_i] | hz_busy[chk_rs2_i] | hz_busy[chk_rd_i]);

    // ------------------------------------------------------------------
    // Starvation: count consecutive cycles the buffer waits without a pop.
    // wb_hold rises on the edge where the count reaches STARVE_MAX and stays
    // up until the cycle after the buffer is seen empty.
    // ------------------------------------------------------------------
    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || fifo_pop) begin
            starve_d = '0;
        end else if (starve_q != STARVE_LIM) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_comb begin
        wb_hold_d = wb_hold_q;
        if (fifo_empty) begin
            wb_hold_d = 1'b0;
        end else if (starve_d == STARVE_LIM) begin
            wb_hold_d = 1'b1;
        end
    end

    assign wb_hold_o = wb_hold_q;

    // ------------------------------------------------------------------
    // Illegal-input checks (simulation only)
    // ------------------------------------------------------------------
`ifndef SYNTHESIS
    a_wb_to_busy : assert property (@(posedge clk) disable iff (reset)
        !(wb_valid_i && busy_q[wb_rd_i]))
        else $error("pipeline writeback to busy register x%0d", wb_rd_i);

    a_iss_to_busy : assert property (@(posedge clk) disable iff (reset)
        !(iss_valid_i && iss_long_i && busy_q[iss_rd_i]))
        else $error("long-latency issue to busy register x%0d", iss_rd_i);
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_wb_arbiter -- directed, table-driven bench for rf_wb_arbiter.
// Each vector is one clock cycle: inputs are driven 1 ns after posedge and
// outputs are compared 2 ns later. Expected values are hand-derived.
// ---------------------------------------------------------------------------
module tb_rf_wb_arbiter;

`ifdef RF_WB_EARLY_CLEAR_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    // hazard while a long result for the checked register is being written
    localparam int HZW = EARLY ? 0 : 1;

    typedef struct {
        logic        wb_v;
        logic [4:0]  wb_rd;
        logic [31:0] wb_d;
        logic        lu_v;
        logic [4:0]  lu_rd;
        logic [31:0] lu_d;
        logic        iss_v;
        logic        iss_l;
        logic [4:0]  iss_rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  crd;
        logic        rst;
        logic        e_en;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_acc;
        logic        e_lrdy;
        logic        e_haz;
        logic        e_hold;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    always #5 clk = ~clk;

    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        wb_accept, wb_hold;
    logic        lu_valid = 1'b0;
    logic [4:0]  lu_rd = '0;
    logic [31:0] lu_data = '0;
    logic        lu_ready;
    logic        iss_valid = 1'b0;
    logic        iss_long = 1'b0;
    logic [4:0]  iss_rd = '0;
    logic [4:0]  chk_rs1 = '0, chk_rs2 = '0, chk_rd = '0;
    logic        hazard;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;

    int n_checks = 0;
    int n_fail   = 0;

    rf_wb_arbiter #(
        .DATA_WIDTH (32),
        .FIFO_DEPTH (4),
        .STARVE_MAX (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wb_valid_i   (wb_valid),
        .wb_rd_i      (wb_rd),
        .wb_data_i    (wb_data),
        .wb_accept_o  (wb_accept),
        .wb_hold_o    (wb_hold),
        .lu_valid_i   (lu_valid),
        .lu_rd_i      (lu_rd),
        .lu_data_i    (lu_data),
        .lu_ready_o   (lu_ready),
        .iss_valid_i  (iss_valid),
        .iss_long_i   (iss_long),
        .iss_rd_i     (iss_rd),
        .chk_rs1_i    (chk_rs1),
        .chk_rs2_i    (chk_rs2),
        .chk_rd_i     (chk_rd),
        .hazard_o     (hazard),
        .rf_wr_en_o   (rf_wr_en),
        .rf_wr_addr_o (rf_wr_addr),
        .rf_wr_data_o (rf_wr_data)
    );

    // ---------------- helpers ----------------
    function automatic vec_t mk(int wv, int wr, int wd, int lv, int lr, int ld,
                                int iv, int il, int ir, int r1, int r2, int cr,
                                int rs, int een, int ea, int ed, int eacc,
                                int elr, int ehz, int eho);
        vec_t v;
        v.wb_v   = wv[0];   v.wb_rd  = 5'(wr);  v.wb_d   = 32'(wd);
        v.lu_v   = lv[0];   v.lu_rd  = 5'(lr);  v.lu_d   = 32'(ld);
        v.iss_v  = iv[0];   v.iss_l  = il[0];   v.iss_rd = 5'(ir);
        v.rs1    = 5'(r1);  v.rs2    = 5'(r2);  v.crd    = 5'(cr);
        v.rst    = rs[0];
        v.e_en   = een[0];  v.e_addr = 5'(ea);  v.e_data = 32'(ed);
        v.e_acc  = eacc[0]; v.e_lrdy = elr[0];
        v.e_haz  = ehz[0];  v.e_hold = eho[0];
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        @(posedge clk);
        #1;
        reset     = v.rst;
        wb_valid  = v.wb_v;  wb_rd  = v.wb_rd;  wb_data = v.wb_d;
        lu_valid  = v.lu_v;  lu_rd  = v.lu_rd;  lu_data = v.lu_d;
        iss_valid = v.iss_v; iss_long = v.iss_l; iss_rd = v.iss_rd;
        chk_rs1   = v.rs1;   chk_rs2 = v.rs2;   chk_rd = v.crd;
        #2;
        chk({tag, ".rf_wr_en"},   32'(rf_wr_en),   32'(v.e_en));
        chk({tag, ".rf_wr_addr"}, 32'(rf_wr_addr), 32'(v.e_addr));
        chk({tag, ".rf_wr_data"}, rf_wr_data,      v.e_data);
        chk({tag, ".wb_accept"},  32'(wb_accept),  32'(v.e_acc));
        chk({tag, ".lu_ready"},   32'(lu_ready),   32'(v.e_lrdy));
        chk({tag, ".hazard"},     32'(hazard),     32'(v.e_haz));
        chk({tag, ".wb_hold"},    32'(wb_hold),    32'(v.e_hold));
    endtask

    // ---------------- stimulus ----------------
    vec_t tbl[27];
    vec_t sa[11];
    vec_t sb[6];

    initial begin
        //            wv wr  wd       lv lr  ld       iv il ir  r1  r2  cr  rst en ea  ed       acc lr hz         ho
        // reset held with every request active: nothing granted, nothing set
        tbl[0]  = mk(1, 3, 'h11,     1, 7, 'h22,     1, 1, 5,  5,  0,  0,  1,  0, 0,  0,       0,  0, 0,         0);
        tbl[1]  = mk(0, 0, 0,        0, 0, 0,        0, 0, 0,  5,  0,  0,  0,  0, 0,  0,       0,  1, 0,         0);
        // scoreboard set, then bypass write of x5 clears it
        tbl[2]  = mk(0, 0, 0,        0, 0, 0,        1, 1, 5,  0,  0,  0,  0,  0, 0,  0,       0,  1, 0,         0);
        tbl[3]  = mk(0, 0, 0,        0, 0, 0,        0, 0, 0,  5,  0,  0,  0,  0, 0,  0,       0,  1, 1,         0);
        tbl[4]  = mk(0, 0, 0,        1, 5, 'hDEAD,   0, 0, 0,  5,  0,  0,  0,  1, 5,  'hDEAD,  0,  1, HZW,       0);
        tbl[5]  = mk(0, 0, 0,        0, 0, 0,        0, 0, 0,  5,  0,  0,  0,  0, 0,  0,       0,  1, 0,         0);
        // conflict: pipeline wins, long result buffered then drained
        tbl[6]  = mk(1, 3, 'h11,     1, 7, 'h22,     0, 0, 0,  0,  0,  0,  0,  1, 3,  'h11,    1,  1, 0,         0);
        tbl[7]  = mk(0, 0, 0,        0, 0, 0,        0, 0, 0,  0,  0,  0,  0,  1, 7,  'h22,    0,  1, 0,         0);
        tbl[8]  = mk(0, 0, 0,        0, 0, 0,        0, 0, 0,  0,  0,  0,  0,  0, 0,  0,       0,  1, 0,         0);
        // x0 writes: granted / accepted but write enable suppressed
        tbl[9]  = mk(1, 0, 'h55,     0, 0, 0,        0, 0, 0,  0,  0,  0,  0,  0, 0,  'h55,    1,  1, 0,         0);
        tbl[10] = mk(0, 0, 0,        1, 0, 'h66,     0, 0, 0,  0,  0,  0,  0,  0, 0,  'h66,    0,  1, 0,         0);
        // x9 RAW via rs2, WAW via rd; short issue to x10 sets nothing
        tbl[11] = mk(0, 0, 0,        0, 0, 0,        1, 1, 9,  0,  0,  0,  0,  0, 0,  0,       0,  1, 0,         0);
        tbl[12] = mk(0, 0, 0,        0, 0, 0,        1, 0, 10, 0,  9,  0,  0,  0, 0,  0,       0,  1, 1,         0);
        tbl[13] = mk(0, 0, 0,        0, 0, 0,        0, 0, 0,  10, 0,  0,  0,  0, 0,  0,       0,  1, 0,         0);
        tbl[14] = mk(0, 0, 0,        0, 0, 0,        0, 0, 0,  0,  0,  9,  0,  0, 0,  0,       0,  1, 1,         0);
        tbl[15] = mk(0, 0, 0,        1, 9, 'h99,     0, 0, 0,  0,  9,  0,  0,  1, 9,  'h99,    0,  1, HZW,       0);
        tbl[16] = mk(0, 0, 0,        0, 0, 0,        0, 0, 0,  0,  9,  0,  0,  0, 0,  0,       0,  1, 0,         0);
        // same-cycle clear and set of x12: set wins
        tbl[17] = mk(0, 0, 0,        1, 12, 'hC,     1, 1, 12, 12, 0,  0,  0,  1, 12, 'hC,     0,  1, 0,         0);
        tbl[18] = mk(0, 0, 0,        0, 0, 0,        0, 0, 0,  12, 0,  0,  0,  0, 0,  0,       0,  1, 1,         0);
        tbl[19] = mk(0, 0, 0,        1, 12, 'hCC,    0, 0, 0,  12, 0,  0,  0,  1, 12, 'hCC,    0,  1, HZW,       0);
        tbl[20] = mk(0, 0, 0,        0, 0, 0,        0, 0, 0,  12, 0,  0,  0,  0, 0,  0,       0,  1, 0,         0);
        // long issue to x0 never marks busy
        tbl[21] = mk(0, 0, 0,        0, 0, 0,        1, 1, 0,  0,  0,  0,  0,  0, 0,  0,       0,  1, 0,         0);
        tbl[22] = mk(0, 0, 0,        0, 0, 0,        0, 0, 0,  0,  0,  0,  0,  0, 0,  0,       0,  1, 0,         0);
        // non-empty buffer blocks bypass: new result queues behind the head
        tbl[23] = mk(1, 1, 'hA1,     1, 13, 'hB1,    0, 0, 0,  0,  0,  0,  0,  1, 1,  'hA1,    1,  1, 0,         0);
        tbl[24] = mk(0, 0, 0,        1, 14, 'hB2,    0, 0, 0,  0,  0,  0,  0,  1, 13, 'hB1,    0,  1, 0,         0);
        tbl[25] = mk(0, 0, 0,        0, 0, 0,        0, 0, 0,  0,  0,  0,  0,  1, 14, 'hB2,    0,  1, 0,         0);
        tbl[26] = mk(0, 0, 0,        0, 0, 0,        0, 0, 0,  0,  0,  0,  0,  0, 0,  0,       0,  1, 0,         0);

        // Full buffer + starvation: pipeline writes every cycle, four results
        // queue, fifth is refused while full, wb_hold drains in order 1..5.
        sa[0]  = mk(1, 1, 'h100,    1, 20, 1,       0, 0, 0,  0,  0,  0,  0,  1, 1,  'h100,   1,  1, 0,         0);
        sa[1]  = mk(1, 2, 'h101,    1, 21, 2,       0, 0, 0,  0,  0,  0,  0,  1, 2,  'h101,   1,  1, 0,         0);
        sa[2]  = mk(1, 3, 'h102,    1, 22, 3,       0, 0, 0,  0,  0,  0,  0,  1, 3,  'h102,   1,  1, 0,         0);
        sa[3]  = mk(1, 4, 'h103,    1, 23, 4,       0, 0, 0,  0,  0,  0,  0,  1, 4,  'h103,   1,  1, 0,         0);
        sa[4]  = mk(1, 5, 'h104,    1, 24, 5,       0, 0, 0,  0,  0,  0,  0,  1, 20, 1,       0,  0, 0,         1);
        sa[5]  = mk(1, 5, 'h104,    1, 24, 5,       0, 0, 0,  0,  0,  0,  0,  1, 21, 2,       0,  1, 0,         1);
        sa[6]  = mk(1, 5, 'h104,    0, 0, 0,        0, 0, 0,  0,  0,  0,  0,  1, 22, 3,       0,  1, 0,         1);
        sa[7]  = mk(1, 5, 'h104,    0, 0, 0,        0, 0, 0,  0,  0,  0,  0,  1, 23, 4,       0,  1, 0,         1);
        sa[8]  = mk(1, 5, 'h104,    0, 0, 0,        0, 0, 0,  0,  0,  0,  0,  1, 24, 5,       0,  1, 0,         1);
        sa[9]  = mk(1, 5, 'h104,    0, 0, 0,        0, 0, 0,  0,  0,  0,  0,  1, 5,  'h104,   1,  1, 0,         1);
        sa[10] = mk(1, 6, 'h105,    0, 0, 0,        0, 0, 0,  0,  0,  0,  0,  1, 6,  'h105,   1,  1, 0,         0);

        // Reset mid-operation: two buffered results and busy x4 are dropped.
        sb[0]  = mk(1, 1, 'h200,    1, 25, 'hA,     1, 1, 4,  0,  0,  0,  0,  1, 1,  'h200,   1,  1, 0,         0);
        sb[1]  = mk(1, 2, 'h201,    1, 26, 'hB,     0, 0, 0,  4,  0,  0,  0,  1, 2,  'h201,   1,  1, 1,         0);
        sb[2]  = mk(1, 3, 'h202,    1, 27, 'hC,     0, 0, 0,  4,  0,  0,  1,  0, 0,  0,       0,  0, 0,         0);
        sb[3]  = mk(0, 0, 0,        0, 0, 0,        0, 0, 0,  4,  0,  0,  0,  0, 0,  0,       0,  1, 0,         0);
        sb[4]  = mk(0, 0, 0,        0, 0, 0,        0, 0, 0,  0,  0,  0,  0,  0, 0,  0,       0,  1, 0,         0);
        sb[5]  = mk(0, 0, 0,        1, 28, 'hD,     0, 0, 0,  0,  0,  0,  0,  1, 28, 'hD,     0,  1, 0,         0);

        reset = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 27; i++) begin
            run_vec(tbl[i], $sformatf("tbl%0d", i));
        end
        for (int i = 0; i < 11; i++) begin
            run_vec(sa[i], $sformatf("starve%0d", i));
        end
        for (int i = 0; i < 6; i++) begin
            run_vec(sb[i], $sformatf("rstmid%0d", i));
        end

        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
